// File: rtl/mux_arb_pkg.sv
// Shared definitions for the N-way arbitrating mux: select width helper,
// arbitration mode constants and the packet-lock FSM state type.
package mux_arb_pkg;

  localparam int RR_FIXED = 0;  // lowest index always wins
  localparam int RR_ROUND = 1;  // rotate priority after each grant

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_state_t;

  // Select width; a single channel still needs a 1-bit index port.
  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_arb_n_rr_arbiter.sv
// Combinational grant logic: fixed priority or round-robin starting after ptr.
// Only requests enabled in mask can be granted.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int RR = RR_ROUND,
  localparam int CW = cw_of(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [CW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [N-1:0] req_m;

  // Pick one masked request; loops run high-to-low so the closest candidate wins.
  always_comb begin
    int idx;
    idx     = 0;
    req_m   = req & mask;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    if (RR == RR_FIXED) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req_m[i]) begin
          gnt_idx = CW'(i);
          gnt_vld = 1'b1;
        end
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        idx = (int'(ptr) + k) % N;
        if (req_m[idx]) begin
          gnt_idx = CW'(idx);
          gnt_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel valid/ready arbitrating mux with a registered output stage.
// Optional packet locking (in_last/out_last + lock FSM) is compiled in when
// MUX_ARB_PKT_LOCK_EN is defined.
module mux_arb_n
  import mux_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int W  = 1,
  parameter int RR = RR_ROUND,
  localparam int CW = cw_of(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]  in_valid,
  output logic [N-1:0]  in_ready,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_sel
`ifdef MUX_ARB_PKT_LOCK_EN
  ,
  input  logic [N-1:0]  in_last,
  output logic          out_last
`endif
);

  logic          ld;
  logic          acc;
  logic [CW-1:0] gnt;
  logic          gnt_vld;
  logic [CW-1:0] ptr;
  logic [N-1:0]  mask;
  logic [W-1:0]  sel_data;

  // Output register can take a new beat when empty or being drained.
  assign ld  = !out_valid || out_ready;
  assign acc = ld && gnt_vld;

`ifdef MUX_ARB_PKT_LOCK_EN
  lock_state_t   state, state_nxt;
  logic [CW-1:0] lock_ch;
  logic          sel_last;

  // Lock state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Enter LOCKED on a non-final beat, leave on the final beat of the locked channel.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc && !sel_last) state_nxt = LOCKED;
      LOCKED:  if (acc && sel_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Remember which channel owns the packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             lock_ch <= '0;
    else if (state == IDLE && acc)       lock_ch <= gnt;
  end

  // While locked only the owning channel is eligible.
  always_comb begin
    for (int i = 0; i < N; i++)
      mask[i] = (state == IDLE) || (lock_ch == CW'(i));
  end

  // End-of-packet flag of the granted channel.
  always_comb begin
    sel_last = 1'b0;
    for (int i = 0; i < N; i++)
      if (gnt == CW'(i)) sel_last = in_last[i];
  end
`else
  assign mask = '1;
`endif

  rr_arbiter #(.N(N), .RR(RR)) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .mask    (mask),
    .gnt_idx (gnt),
    .gnt_vld (gnt_vld)
  );

  // One-hot ready to the granted channel and data select for it.
  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == CW'(i)) begin
        in_ready[i] = acc;
        sel_data    = in_data[i*W +: W];
      end
    end
  end

  // Output stage and round-robin pointer; ptr moves only on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= CW'(N - 1);
`ifdef MUX_ARB_PKT_LOCK_EN
      out_last  <= 1'b0;
`endif
    end else if (acc) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= gnt;
      ptr       <= gnt;
`ifdef MUX_ARB_PKT_LOCK_EN
      out_last  <= sel_last;
`endif
    end else if (ld) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: round-robin, fixed priority, N=1 and
// (with MUX_ARB_PKT_LOCK_EN) packet locking.
module tb_mux_arb_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Round-robin instance, N=4 W=8
  logic [31:0] a_data;
  logic [3:0]  a_vld, a_rdy;
  logic        a_ordy, a_ov;
  logic [7:0]  a_od;
  logic [1:0]  a_sel;
  // Fixed-priority instance, N=4 W=8
  logic [31:0] b_data;
  logic [3:0]  b_vld, b_rdy;
  logic        b_ordy, b_ov;
  logic [7:0]  b_od;
  logic [1:0]  b_sel;
  // Single-channel instance, W=8
  logic [7:0]  c_data;
  logic        c_vld, c_rdy, c_ordy, c_ov, c_sel;
  logic [7:0]  c_od;
`ifdef MUX_ARB_PKT_LOCK_EN
  logic [3:0]  a_last, b_last;
  logic        c_last, a_olast, b_olast, c_olast;
`endif

  mux_arb_n #(.N(4), .W(8), .RR(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_vld), .in_ready(a_rdy),
    .out_data(a_od), .out_valid(a_ov), .out_ready(a_ordy), .out_sel(a_sel)
`ifdef MUX_ARB_PKT_LOCK_EN
    , .in_last(a_last), .out_last(a_olast)
`endif
  );

  mux_arb_n #(.N(4), .W(8), .RR(0)) u_fp (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_vld), .in_ready(b_rdy),
    .out_data(b_od), .out_valid(b_ov), .out_ready(b_ordy), .out_sel(b_sel)
`ifdef MUX_ARB_PKT_LOCK_EN
    , .in_last(b_last), .out_last(b_olast)
`endif
  );

  mux_arb_n #(.N(1), .W(8), .RR(1)) u_one (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_vld), .in_ready(c_rdy),
    .out_data(c_od), .out_valid(c_ov), .out_ready(c_ordy), .out_sel(c_sel)
`ifdef MUX_ARB_PKT_LOCK_EN
    , .in_last(c_last), .out_last(c_olast)
`endif
  );

  typedef struct {
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [7:0] od;
    logic [1:0] sel;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle on the round-robin instance: ready before the edge, outputs after.
  task automatic a_cycle(input string tag, input logic [3:0] vld, input logic ordy,
                         input logic [3:0] erdy, input logic eov,
                         input logic [7:0] eod, input logic [1:0] esel);
    a_vld  = vld;
    a_ordy = ordy;
    #1;
    chk({tag, " in_ready"}, 64'(a_rdy), 64'(erdy));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 64'(a_ov), 64'(eov));
    chk({tag, " out_data"}, 64'(a_od), 64'(eod));
    chk({tag, " out_sel"}, 64'(a_sel), 64'(esel));
  endtask

  initial begin
    // ch i carries 0x10+i; ptr starts at 3 so ch0 is first
    tbl[0] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tbl[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tbl[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tbl[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[5] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0};
    tbl[6] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tbl[7] = '{4'b0101, 1'b0, 4'b0000, 1'b1, 8'h12, 2'd2};
    tbl[8] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[9] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};

    rst    = 1'b1;
    a_data = 32'h13121110; a_vld = '0; a_ordy = 1'b0;
    b_data = 32'h23222120; b_vld = '0; b_ordy = 1'b0;
    c_data = 8'h00;        c_vld = 1'b0; c_ordy = 1'b0;
`ifdef MUX_ARB_PKT_LOCK_EN
    a_last = 4'hF; b_last = 4'hF; c_last = 1'b1;
`endif
    @(posedge clk);
    #1;
    chk("reset out_valid", 64'(a_ov), 64'(0));
    chk("reset out_data", 64'(a_od), 64'(0));
    chk("reset out_sel", 64'(a_sel), 64'(0));
    rst = 1'b0;

    // Table: rotation, idle, stall, sparse valids
    for (int i = 0; i < 10; i++)
      a_cycle($sformatf("rr vec%0d", i), tbl[i].vld, tbl[i].ordy, tbl[i].rdy,
              tbl[i].ov, tbl[i].od, tbl[i].sel);

    // ch2 carries 0xA5, then downstream stalls for 3 cycles
    a_data = 32'h13A51110;
    a_cycle("a5 load", 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
    for (int i = 0; i < 3; i++)
      a_cycle($sformatf("a5 hold%0d", i), 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2);

    // Reset while a beat is held: discarded immediately, ch0 first afterwards
    a_data = 32'h13121110;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", 64'(a_ov), 64'(0));
    chk("midrst out_data", 64'(a_od), 64'(0));
    chk("midrst out_sel", 64'(a_sel), 64'(0));
    rst = 1'b0;
    a_cycle("post rst", 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);

`ifdef MUX_ARB_PKT_LOCK_EN
    // ch1 3-beat packet with ch0 valid throughout; ptr is 0 here
    a_last = 4'b1101;
    a_cycle("lock b1", 4'b0011, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);
    chk("lock b1 out_last", 64'(a_olast), 64'(0));
    a_cycle("lock b2", 4'b0011, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);
    chk("lock b2 out_last", 64'(a_olast), 64'(0));
    a_last = 4'b1111;
    a_cycle("lock b3", 4'b0011, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);
    chk("lock b3 out_last", 64'(a_olast), 64'(1));
    a_cycle("lock rel", 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
`endif
    a_vld = '0;

    // Fixed priority: ch0 always wins while valid
    b_vld  = 4'b1111;
    b_ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("fp%0d in_ready", i), 64'(b_rdy), 64'(4'b0001));
      @(posedge clk);
      #1;
      chk($sformatf("fp%0d out_sel", i), 64'(b_sel), 64'(0));
      chk($sformatf("fp%0d out_data", i), 64'(b_od), 64'(8'h20));
    end
    b_vld = 4'b1100;
    #1;
    chk("fp hi in_ready", 64'(b_rdy), 64'(4'b0100));
    @(posedge clk);
    #1;
    chk("fp hi out_sel", 64'(b_sel), 64'(2));
    chk("fp hi out_data", 64'(b_od), 64'(8'h22));
    b_vld = '0;

    // N=1: pulse one beat through the pipeline stage
    c_data = 8'h01;
    c_vld  = 1'b1;
    c_ordy = 1'b1;
    #1;
    chk("n1 in_ready", 64'(c_rdy), 64'(1));
    @(posedge clk);
    #1;
    chk("n1 out_valid", 64'(c_ov), 64'(1));
    chk("n1 out_data", 64'(c_od), 64'(1));
    chk("n1 out_sel", 64'(c_sel), 64'(0));
    c_vld = 1'b0;
    @(posedge clk);
    #1;
    chk("n1 drain out_valid", 64'(c_ov), 64'(0));
    chk("n1 drain out_data", 64'(c_od), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arb_n.md
MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 The parameter N SHALL default to 2 and SHALL set the number of input channels (legal values 1..16).
REQ-002 The parameter W SHALL default to 1 and SHALL set the data width in bits per channel (legal values 1..64).
REQ-003 The parameter RR SHALL default to 1, where 1 means round-robin arbitration and 0 means fixed priority with the lowest index winning.
REQ-004 The design SHALL have one clock and an asynchronous, active-high reset.
REQ-005 The port clk SHALL be an input, 1 bit wide, and SHALL be the only clock; all state updates on its rising edge.
REQ-006 The port rst SHALL be an input, 1 bit wide, and SHALL be an asynchronous, active-high reset.
REQ-007 The port in_data SHALL be an input, N*W bits wide, with channel i occupying bits [i*W +: W].
REQ-008 The port in_valid SHALL be an input, N bits wide, carrying one valid per channel.
REQ-009 The port in_ready SHALL be an output, N bits wide, carrying one ready per channel.
REQ-010 The port out_data SHALL be an output, W bits wide, driven from a register.
REQ-011 The port out_valid SHALL be an output, 1 bit wide, driven from a register.
REQ-012 The port out_ready SHALL be an input, 1 bit wide, carrying downstream ready.
REQ-013 The port out_sel SHALL be an output, CW = max(1, clog2(N)) bits wide, giving the channel index of the current out_data.

Function
REQ-014 The output register SHALL be loadable (ld) when out_valid == 0 or out_ready == 1.
REQ-015 Arbitration SHALL be recomputed combinationally every cycle over in_valid; the grant g is valid only if at least one in_valid is high.
REQ-016 When RR = 0, g SHALL be the lowest i with in_valid[i] == 1.
REQ-017 When RR = 1, g SHALL be the first valid i found searching ptr+1, ptr+2, ... with wrap-around modulo N.
REQ-018 in_ready[i] SHALL equal ld && (i == g) && grant valid; at most one in_ready bit is high at any time.
REQ-019 A beat SHALL be accepted from channel i when in_valid[i] and in_ready[i] are both high.
REQ-020 On acceptance, the next cycle SHALL have out_data = channel data, out_sel = i and out_valid = 1, giving a latency of exactly 1 cycle.
REQ-021 When ld is high and no channel is valid, the next cycle SHALL have out_valid = 0; out_data and out_sel hold their values.
REQ-022 While out_valid && !out_ready, out_data and out_sel SHALL be held stable and every in_ready SHALL be 0.
REQ-023 Sustained throughput SHALL be 1 beat per cycle whenever out_ready stays high.
REQ-024 ptr SHALL update to i only on acceptance from channel i and SHALL be unchanged otherwise.
REQ-025 When N = 1, the block SHALL act as a 1-deep registered pipeline stage and out_sel SHALL be constantly 0.
REQ-026 A channel that drops in_valid without being accepted SHALL lose nothing and SHALL cause no ptr change.

Reset
REQ-027 Asserting rst SHALL immediately force out_valid = 0, out_data = 0, out_sel = 0, ptr = N-1 (so channel 0 has first priority) and, when compiled in, the lock FSM to IDLE.
REQ-028 A beat held in the output register when rst asserts mid-operation SHALL be discarded.
REQ-029 Acceptance SHALL be possible on the first clock edge after rst deasserts.

Configuration
REQ-030 When the macro MUX_ARB_PKT_LOCK_EN is defined, the design SHALL add an input in_last (N bits, end-of-packet per channel) and an output out_last (1 bit, registered alongside out_data, reset value 0).
REQ-031 With MUX_ARB_PKT_LOCK_EN defined, the lock FSM SHALL be IDLE -> LOCKED on acceptance of a beat with in_last == 0, recording the locked channel k.
REQ-032 In LOCKED, only channel k SHALL be eligible for grant, regardless of other valids or RR.
REQ-033 The FSM SHALL go LOCKED -> IDLE on acceptance of a beat from k with in_last == 1; a single-beat packet never enters LOCKED.
REQ-034 Without MUX_ARB_PKT_LOCK_EN, the design SHALL have no in_last, out_last or FSM, and every beat SHALL be arbitrated independently.

Structure
REQ-035 The package mux_arb_pkg SHALL hold the CW width function/constant, the lock FSM state typedef (IDLE, LOCKED) and the RR mode constants.
REQ-036 The sub-module rr_arbiter (N, RR; inputs req, ptr, mask; outputs grant index and grant valid) SHALL hold the combinational grant logic, and the top SHALL own the registers and FSM.

Verification
REQ-037 With N=4, W=8, RR=1, in_valid=4'b1111 constant and out_ready=1, the bench SHALL check out_sel = 0,1,2,3,0 on consecutive cycles.
REQ-038 With N=4, RR=0 and all channels valid, the bench SHALL check out_sel stays 0 each cycle and in_ready = 4'b0001.
REQ-039 With ch2 data 0xA5 accepted and then out_ready held low for 3 cycles, the bench SHALL check out_data = 0xA5 and out_valid = 1 stable, with in_ready = 0 throughout.
REQ-040 With rst asserted while out_valid = 1 and then released, the bench SHALL check out_valid = 0 and out_data = 0, and that the next grant goes to ch0 with all channels valid.
REQ-041 With MUX_ARB_PKT_LOCK_EN, ch1 sending a 3-beat packet (last on beat 3) and ch0 valid throughout, RR=1, the bench SHALL check out_sel = 1,1,1, then 0.
REQ-042 With N=1 and in_valid pulsed with data 1, the bench SHALL check out_valid = 1 and out_data = 1 one cycle later.
